// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_sequencer
// Brief    : Feeds word-wide operands to a 4-bit adder one nibble per cycle,
//            chaining the carry and assembling the result plus status flags.
//            Macro ALU_SEQ_SUB_EN enables subtract (in_op=1 -> A - B).
// Revision : 1.0 - initial release
// ============================================================================
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_op,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_result,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_result,
    output logic                 out_carry,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic                 out_ovf
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     result_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;

    logic             w_sub;
    logic [W-1:0]     b_d;
    logic [IDX_W+1:0] w_bit_base;
    logic             w_run;

`ifdef ALU_SEQ_SUB_EN
    assign w_sub = in_op;
`else
    logic w_unused_op;
    assign w_unused_op = in_op;
    assign w_sub       = 1'b0;
`endif

    // Subtract is A + ~B + 1: the +1 comes from seeding the carry register.
    assign b_d        = in_b ^ {W{w_sub}};
    assign w_bit_base = {idx_q, 2'b00};
    assign w_run      = (state_q == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= b_d;
                        idx_q   <= '0;
                        carry_q <= w_sub;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q[w_bit_base +: 4] <= add_result;
                    carry_q                   <= add_cout;
                    idx_q                     <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    assign add_a   = w_run ? a_q[w_bit_base +: 4] : 4'h0;
    assign add_b   = w_run ? b_q[w_bit_base +: 4] : 4'h0;
    assign add_cin = w_run & carry_q;

    // Result and flags are masked outside DONE so an aborted or in-flight
    // transaction never shows partial data.
    assign out_result = out_valid ? result_q : '0;
    assign out_carry  = out_valid & carry_q;
    assign out_zero   = out_valid & (result_q == '0);
    assign out_neg    = out_valid & result_q[W-1];
    assign out_ovf    = out_valid & (a_q[W-1] == b_q[W-1]) & (result_q[W-1] != a_q[W-1]);

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// Testbench for alu_nibble_sequencer: models the 4-bit adder and checks every
// transaction against a word-level arithmetic reference.
module tb_alu_nibble_sequencer;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_op;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_result;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_neg;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         neg;
        logic         ovf;
    } exp_t;

    always #5 clk = ~clk;

    assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_result(add_result), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        exp_t e;
        bit   sub;
        longint ua, ub, sa, sb, t;
`ifdef ALU_SEQ_SUB_EN
        sub = op;
`else
        sub = op & 1'b0;
`endif
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            e.res   = W'(ua - ub);
            e.carry = (ua >= ub);
            t       = sa - sb;
        end else begin
            e.res   = W'(ua + ub);
            e.carry = ((ua + ub) >= (longint'(1) << W));
            t       = sa + sb;
        end
        e.zero = (e.res == '0);
        e.neg  = e.res[W-1];
        e.ovf  = (t > ((longint'(1) << (W-1)) - 1)) || (t < -(longint'(1) << (W-1)));
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.res = out_result; o.carry = out_carry; o.zero = out_zero;
        o.neg = out_neg;    o.ovf = out_ovf;
        return o;
    endfunction

    // Drives one request; returns with the accept edge just past.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok       = in_ready;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        ok = out_valid;
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, add_a, add_b, add_cin, out_result, out_carry, out_zero, out_neg, out_ovf} !==
            {1'b1, {(W+14){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b a=%h b=%h cin=%b res=%h flags=%b%b%b%b", in_ready, out_valid,
                     add_a, add_b, add_cin, out_result, out_carry, out_zero, out_neg, out_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        bit ok1, ok2; int lat; exp_t e;
        e = model(16'h1234, 16'h0FFF, 1'b0);
        send(16'h1234, 16'h0FFF, 1'b0, ok1);
        wait_valid(lat, ok2);
        checks++;
        if (!ok1 || !ok2 || lat !== NIBBLES + 1) begin
            errors++;
            $display("FAIL add_latency: got %0d (ok=%b%b), need %0d", lat, ok1, ok2, NIBBLES + 1);
        end
        checks++;
        if (observed() !== e || out_result !== 16'h2233) begin
            errors++;
            $display("FAIL add_result: got %h, need %h (0x2233)", observed(), e);
        end
        handoff();
    endtask

    task automatic test_wrap();
        bit ok; exp_t e;
        e = model(16'hFFFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, ok);
        for (int i = 0; i < NIBBLES; i++) begin
            checks++;
            if (add_cin !== (i != 0) || add_a !== 4'hF) begin
                errors++;
                $display("FAIL wrap_slice%0d: cin=%b a=%h, need cin=%b a=f", i, add_cin, add_a, (i != 0));
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok || out_valid !== 1'b1 || observed() !== e || out_zero !== 1'b1 || out_carry !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result: vld=%b got %h, need %h", out_valid, observed(), e);
        end
        handoff();
    endtask

    task automatic test_sub();
        bit ok1, ok2; int lat; exp_t e; logic [W-1:0] lit;
`ifdef ALU_SEQ_SUB_EN
        lit = 16'hFFFE;
`else
        lit = 16'h000C;
`endif
        e = model(16'h0005, 16'h0007, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, ok1);
        wait_valid(lat, ok2);
        checks++;
        if (!ok1 || !ok2 || observed() !== e || out_result !== lit) begin
            errors++;
            $display("FAIL sub_result: got %h, need %h (res %h)", observed(), e, lit);
        end
        handoff();
    endtask

    task automatic test_overflow();
        bit ok1, ok2; int lat; exp_t e;
        e = model(16'h7FFF, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, ok1);
        wait_valid(lat, ok2);
        checks++;
        if (!ok1 || !ok2 || observed() !== e || out_ovf !== 1'b1 || out_neg !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add: got %h, need %h", observed(), e);
        end
        handoff();
        e = model(16'h8000, 16'h0001, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, ok1);
        wait_valid(lat, ok2);
        checks++;
        if (!ok1 || !ok2 || observed() !== e) begin
            errors++;
            $display("FAIL ovf_sub: got %h, need %h", observed(), e);
        end
        handoff();
    endtask

    task automatic test_random();
        bit ok1, ok2; int lat; exp_t e; logic [W-1:0] a, b; logic op;
        for (int n = 0; n < 24; n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 1'($urandom);
            e  = model(a, b, op);
            send(a, b, op, ok1);
            wait_valid(lat, ok2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (!ok1 || !ok2 || observed() !== e) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h op=%b got %h, need %h", n, a, b, op, observed(), e);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        bit ok1, ok2; int lat; exp_t snap, e2;
        send(16'h4321, 16'h1111, 1'b0, ok1);
        wait_valid(lat, ok2);
        snap = model(16'h4321, 16'h1111, 1'b0);
        e2   = model(16'h0AAA, 16'h0555, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = i[0]; in_a = 16'h0AAA; in_b = 16'h0555; in_op = 1'b0;
            #1;
            checks++;
            if (!ok1 || !ok2 || observed() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure%0d: got %h vld=%b rdy=%b, need %h 1 0", i, observed(), out_valid,
                         in_ready, snap);
            end
        end
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handoff: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: in_ready=%b, need 0", in_ready);
        end
        wait_valid(lat, ok2);
        checks++;
        if (!ok2 || observed() !== e2) begin
            errors++;
            $display("FAIL bp_second: got %h, need %h", observed(), e2);
        end
        handoff();
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2; int lat; exp_t e;
        send(16'hABCD, 16'h1111, 1'b0, ok1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok1 || add_a !== 4'hB) begin
            errors++;
            $display("FAIL mid_slice2: add_a=%h, need b", add_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, add_a, add_b, add_cin, out_result, out_carry, out_zero, out_neg, out_ovf} !==
            {1'b1, {(W+14){1'b0}}}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b a=%h b=%h cin=%b res=%h", in_ready, out_valid, add_a, add_b,
                     add_cin, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = model(16'h00FF, 16'h0001, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, ok1);
        wait_valid(lat, ok2);
        checks++;
        if (!ok1 || !ok2 || observed() !== e || out_result !== 16'h0100) begin
            errors++;
            $display("FAIL after_reset: got %h, need %h", observed(), e);
        end
        handoff();
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
